// File: rtl/ysyx_22050854_ifu.sv
// ysyx_22050854_ifu -- instruction fetch unit between the PC stage and decode.
//
// Issues one instruction-memory request per pc_i. The returned word goes into
// the IF/ID register (if_valid/if_pc/if_inst), where it waits until decode
// accepts it. A redirect (jump) flushes whatever is in flight. A word-misaligned
// pc_i produces a NOP slot flagged by if_misalign, and no memory request.
//
// Ports
//   clk, rst          single clock; asynchronous active-high reset
//   pc_i              fetch address from the PC stage (registered there)
//   jump              redirect: the fetch in progress is stale
//   stall             decode cannot accept the current IF/ID contents
//   imem_req_*        request channel (valid/ready, word-aligned address)
//   imem_resp_*       response channel (single-cycle data pulse)
//   fetch_busy        PC-stage suspend; pc_i may advance only while 0
//   if_valid/if_pc/if_inst/if_misalign   IF/ID register contents
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | first cycle after reset, nothing issued yet
// REQ    | presenting pc_i to instruction memory
// WAIT   | request accepted, waiting for its response
// DROP   | redirected while waiting; the pending response is discarded
// DONE   | IF/ID register holds an instruction for decode

module ysyx_22050854_ifu #(
  parameter logic [31:0] RESET_PC = 32'h80000000,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        jump,
  input  logic        stall,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        fetch_busy,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_misalign
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DROP = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] req_pc;
  logic        misaligned;

  assign misaligned = (pc_i[1:0] != 2'b00);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A redirect in DROP does not leave DROP: the response
  // of the abandoned request is still owed and must be swallowed first.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        if (jump) begin
          state_nxt = S_REQ;
        end else if (misaligned) begin
          state_nxt = S_DONE;
        end else if (imem_req_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (jump) begin
          state_nxt = imem_resp_valid ? S_REQ : S_DROP;
        end else if (imem_resp_valid) begin
          state_nxt = S_DONE;
        end
      end
      S_DROP: begin
        if (imem_resp_valid) begin
          state_nxt = S_REQ;
        end
      end
      S_DONE: begin
        if (jump || !stall) begin
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs. The request is masked during a redirect so a stale pc_i can
  // never be accepted; the next cycle presents the new target instead.
  always_comb begin
    imem_req_valid = (state == S_REQ) && !misaligned && !jump;
    imem_req_addr  = {pc_i[31:2], 2'b00};
    fetch_busy     = !((state == S_DONE) && !stall);
  end

  // Request-address latch and IF/ID register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_pc      <= RESET_PC;
      if_valid    <= 1'b0;
      if_pc       <= RESET_PC;
      if_inst     <= NOP_INST;
      if_misalign <= 1'b0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        req_pc <= pc_i;
      end
      if (jump) begin
        // Redirect beats stall; the slot becomes a bubble.
        if_valid    <= 1'b0;
        if_inst     <= NOP_INST;
        if_misalign <= 1'b0;
      end else begin
        case (state)
          S_REQ: begin
            if (misaligned) begin
              if_valid    <= 1'b1;
              if_pc       <= pc_i;
              if_inst     <= NOP_INST;
              if_misalign <= 1'b1;
            end
          end
          S_WAIT: begin
            if (imem_resp_valid) begin
              if_valid    <= 1'b1;
              if_pc       <= req_pc;
              if_inst     <= imem_resp_data;
              if_misalign <= 1'b0;
            end
          end
          S_DONE: begin
            if (!stall) begin
              if_valid    <= 1'b0;
              if_misalign <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050854_ifu.sv
// Testbench for ysyx_22050854_ifu. A PC-stage model and an instruction-memory
// model drive the DUT with random ready/latency/stall/jump; the expected
// stream of consumed instructions is pushed into a queue by the stimulus side
// and popped by an independent monitor whenever decode consumes a slot.

module tb_ysyx_22050854_ifu;

  localparam logic [31:0] RESET_PC = 32'h80000000;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        jump;
  logic        stall;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        fetch_busy;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_misalign;

  ysyx_22050854_ifu #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_i            (pc_i),
    .jump            (jump),
    .stall           (stall),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .fetch_busy      (fetch_busy),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .if_misalign     (if_misalign)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_cons = 0;
  int n_mis_cons = 0;
  int n_req = 0;
  int last_cons = 0;

  // stimulus knobs
  int unsigned p_ready = 100;  // percent
  int unsigned max_dly = 1;    // response latency 1..max_dly cycles
  int unsigned p_jump = 0;     // per mille
  int unsigned p_stall = 0;    // percent
  int unsigned p_spur = 0;     // percent, unsolicited responses when idle
  int unsigned p_mis = 15;     // percent of jump targets that are misaligned

  // PC-stage and memory model state
  logic [31:0] pc;
  logic        outstanding = 1'b0;
  int          cnt = 0;
  logic [31:0] mem_addr;
  logic        accepted;
  logic        force_jump = 1'b0;
  logic [31:0] force_tgt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RESET_PC) return 32'h00100093;
    return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  function automatic exp_t expect_for(input logic [31:0] p);
    exp_t e;
    e.pc   = p;
    e.mis  = (p[1:0] != 2'b00);
    e.inst = e.mis ? NOP : mem_word({p[31:2], 2'b00});
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock of stimulus: memory response, random inputs, PC-stage update.
  task automatic step();
    logic [31:0] target;
    @(negedge clk);
    cyc++;
    imem_resp_valid = 1'b0;
    if (outstanding) begin
      cnt--;
      if (cnt <= 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mem_addr);
        outstanding     = 1'b0;
      end
    end else if ($urandom_range(99) < p_spur) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hDEAD0000 | 32'($urandom_range(65535));
    end
    imem_req_ready = ($urandom_range(99) < p_ready);
    stall          = ($urandom_range(99) < p_stall);
    pc_i           = pc;
    jump           = 1'b0;
    if (!rst && (force_jump || $urandom_range(999) < p_jump)) begin
      if (force_jump) begin
        target = force_tgt;
      end else begin
        target = 32'h80000000 + 32'($urandom_range(4095)) * 32'd4;
        if ($urandom_range(99) < p_mis) target = target + 32'($urandom_range(3, 1));
      end
      force_jump = 1'b0;
      jump = 1'b1;
      pc   = target;
      pc_i = target;
      exp_q.delete();
      exp_q.push_back(expect_for(target));
    end
    #1;
    accepted = imem_req_valid && imem_req_ready;
    if (accepted) begin
      check("single_outstanding", 32'(outstanding), 32'd0);
      outstanding = 1'b1;
      cnt         = $urandom_range(max_dly, 1);
      mem_addr    = imem_req_addr;
      n_req++;
    end
    if (!rst && !jump && if_valid && !fetch_busy) begin
      pc = pc + 32'd4;
      exp_q.push_back(expect_for(pc));
    end
  endtask

  // Monitor: protocol rules every cycle, scoreboard on each consumed slot.
  logic        prev_jump = 1'b0;
  logic        prev_hold = 1'b0;
  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr, prev_pc, prev_inst;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_pc", if_pc, RESET_PC);
        check("rst_if_inst", if_inst, NOP);
        check("rst_if_misalign", 32'(if_misalign), 32'd0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_fetch_busy", 32'(fetch_busy), 32'd1);
        prev_jump = 1'b0;
        prev_hold = 1'b0;
        prev_pend = 1'b0;
        last_cons = cyc;
      end else begin
        if (prev_jump) begin
          check("flush_valid", 32'(if_valid), 32'd0);
          check("flush_inst", if_inst, NOP);
        end
        if (prev_hold) begin
          check("hold_valid", 32'(if_valid), 32'd1);
          check("hold_pc", if_pc, prev_pc);
          check("hold_inst", if_inst, prev_inst);
        end
        check("fetch_busy", 32'(fetch_busy), if_valid ? 32'(stall) : 32'd1);
        if (imem_req_valid) begin
          check("req_addr", imem_req_addr, {pc_i[31:2], 2'b00});
          check("req_aligned", 32'(pc_i[1:0]), 32'd0);
          check("req_while_holding", 32'(if_valid), 32'd0);
        end
        if (prev_pend && !jump) begin
          check("req_kept", 32'(imem_req_valid), 32'd1);
          check("req_addr_stable", imem_req_addr, prev_addr);
        end
        if (if_valid && !fetch_busy && !jump) begin
          n_cons++;
          last_cons = cyc;
          if (if_misalign) n_mis_cons++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_empty: consumed pc %h inst %h, nothing expected", if_pc, if_inst);
          end else begin
            e = exp_q.pop_front();
            check("cons_pc", if_pc, e.pc);
            check("cons_inst", if_inst, e.inst);
            check("cons_misalign", 32'(if_misalign), 32'(e.mis));
          end
        end
        if (cyc - last_cons > 300) begin
          n_cmp++;
          n_err++;
          $display("FAIL watchdog: no instruction consumed for %0d cycles, required progress", cyc - last_cons);
          last_cons = cyc;
        end
        prev_jump = jump;
        prev_hold = if_valid && stall && !jump;
        prev_pend = imem_req_valid && !imem_req_ready;
        prev_addr = imem_req_addr;
        prev_pc   = if_pc;
        prev_inst = if_inst;
      end
    end
  end

  initial begin
    int rel_cyc, acc_cyc, val_cyc, k, req_before;
    logic [31:0] acc_addr, v_pc, v_inst;
    logic found;

    rst = 1'b1;
    pc = RESET_PC;
    pc_i = RESET_PC;
    jump = 1'b0;
    stall = 1'b0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'd0;
    exp_q.push_back(expect_for(RESET_PC));
    repeat (3) step();

    // First fetch at minimum latency.
    rst = 1'b0;
    rel_cyc = cyc;
    acc_cyc = -1;
    val_cyc = -1;
    acc_addr = 32'd0;
    v_pc = 32'd0;
    v_inst = 32'd0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (acc_cyc < 0 && accepted) begin acc_cyc = cyc; acc_addr = imem_req_addr; end
      if (val_cyc < 0 && if_valid) begin val_cyc = cyc; v_pc = if_pc; v_inst = if_inst; end
    end
    check("first_req_cycle", 32'(acc_cyc - rel_cyc), 32'd1);
    check("first_req_addr", acc_addr, 32'h80000000);
    check("first_latency", 32'(val_cyc - acc_cyc), 32'd2);
    check("first_if_pc", v_pc, 32'h80000000);
    check("first_if_inst", v_inst, 32'h00100093);

    // Random traffic in segments with different pressure.
    for (int s = 0; s < 6; s++) begin
      p_ready = $urandom_range(100, 20);
      max_dly = $urandom_range(4, 1);
      p_jump  = $urandom_range(80, 0);
      p_stall = $urandom_range(50, 0);
      p_spur  = $urandom_range(20, 0);
      repeat (500) step();
    end

    // Misaligned target: NOP slots, no memory traffic.
    p_jump = 0;
    p_spur = 0;
    force_tgt = 32'h80000002;
    force_jump = 1'b1;
    step();
    req_before = n_req;
    n_mis_cons = 0;
    repeat (40) step();
    check("misalign_no_request", 32'(n_req - req_before), 32'd0);
    check("misalign_consumed", 32'(n_mis_cons > 0), 32'd1);

    // Redirect back to an aligned stream.
    force_tgt = 32'h80000100;
    force_jump = 1'b1;
    p_jump = 30;
    p_stall = 30;
    p_ready = 60;
    max_dly = 3;
    repeat (300) step();

    // Reset while a request is in flight; its response lands inside reset.
    p_jump = 0;
    p_spur = 0;
    p_ready = 100;
    p_stall = 0;
    accepted = 1'b0;
    k = 0;
    while (!accepted && k < 100) begin step(); k++; end
    check("wait_for_req", 32'(accepted), 32'd1);
    cnt = 3;
    step();
    rst = 1'b1;
    pc = 32'h80000400;
    exp_q.delete();
    exp_q.push_back(expect_for(pc));
    repeat (4) step();
    check("resp_in_reset", 32'(outstanding), 32'd0);
    rst = 1'b0;
    p_spur = 100;
    found = 1'b0;
    acc_addr = 32'd0;
    for (int i = 0; i < 10; i++) begin
      step();
      p_spur = 0;
      if (!found && accepted) begin found = 1'b1; acc_addr = imem_req_addr; end
    end
    check("post_reset_req_addr", acc_addr, 32'h80000400);

    p_jump = 40;
    p_stall = 30;
    p_ready = 70;
    max_dly = 4;
    repeat (300) step();

    check("consumed_enough", 32'(n_cons > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
